// File: rtl/pkt_hdr_check.sv
// pkt_hdr_check: packet header/checksum filter with a speculative store-and-forward buffer.
//
// Incoming packets are framed by din_sop/din_eop and have no backpressure:
// word0[7:0] is the payload length L, word1 is a ones-complement checksum and the
// payload words follow. Payload words are written at a speculative write pointer.
// At eop the packet is either committed, which exposes it to the output side, or
// dropped, which rewinds the write pointer to the last commit. Only committed words
// are presented on dout under a valid/ready handshake.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   din, din_vld, din_sop, din_eop  input packet stream
//   dout, dout_vld, dout_sop, dout_eop, dout_rdy  payload output stream
//   err_vld, err_code             one-cycle drop pulse and its cause
//                                 (1 = length, 2 = checksum, 3 = overflow/truncation)
//   good_cnt, err_cnt             accepted / dropped packet counters
//
// Build option: define PKT_STAT_CNT_EN to implement the saturating packet counters;
// without it good_cnt/err_cnt are tied to zero.
module pkt_hdr_check #(
   parameter int unsigned DEPTH = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] din,
   input  logic        din_vld,
   input  logic        din_sop,
   input  logic        din_eop,
   output logic [15:0] dout,
   output logic        dout_vld,
   output logic        dout_sop,
   output logic        dout_eop,
   input  logic        dout_rdy,
   output logic        err_vld,
   output logic [1:0]  err_code,
   output logic [15:0] good_cnt,
   output logic [15:0] err_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DepthPtr = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StHdrChk, StPayload} state_e;

   state_e      state_q, state_d;
   logic [AW:0] wptr_q, wptr_d;   // speculative write pointer
   logic [AW:0] cptr_q, cptr_d;   // committed write pointer
   logic [AW:0] rptr_q;           // read pointer
   logic [7:0]  len_q, len_d;
   logic [8:0]  cnt_q, cnt_d;     // saturates; any value above 255 is a mismatch
   logic [15:0] acc_q, acc_d;
   logic        ovf_q, ovf_d;
   logic        err_vld_q;
   logic [1:0]  err_code_q;
   logic [15:0] dout_q;
   logic        dout_vld_q, dout_sop_q, dout_eop_q;

   // Each entry is {first payload word, last payload word, data}.
   logic [17:0] mem [DEPTH];

   logic        hdr_start, seed, pay_word, wr_en, drop, commit, full;
   logic [1:0]  drop_code;
   logic [16:0] sum;
   logic [15:0] acc_add;
   logic [8:0]  cnt_inc;

   assign full    = (wptr_q - rptr_q) == DepthPtr;
   assign sum     = {1'b0, acc_q} + {1'b0, din};
   assign acc_add = sum[15:0] + {15'd0, sum[16]};
   assign cnt_inc = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;

   // ---------------------------------------------------------------- FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- FSM next state
   always_comb begin
      state_d = state_q;
      if (din_vld) begin
         if (din_sop) begin
            // sop always opens a new header, whatever was in flight.
            state_d = din_eop ? StIdle : StHdrChk;
         end else begin
            unique case (state_q)
               StIdle:    state_d = StIdle;
               StHdrChk:  state_d = din_eop ? StIdle : StPayload;
               StPayload: state_d = din_eop ? StIdle : StPayload;
               default:   state_d = StIdle;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- FSM outputs
   always_comb begin
      hdr_start = 1'b0;
      seed      = 1'b0;
      pay_word  = 1'b0;
      drop      = 1'b0;
      drop_code = 2'd0;
      commit    = 1'b0;
      if (din_vld) begin
         if (din_sop) begin
            hdr_start = 1'b1;
            // Mid-packet sop aborts the old packet; sop+eop is a one-word runt.
            drop      = din_eop || (state_q != StIdle);
            drop_code = 2'd3;
         end else begin
            unique case (state_q)
               StIdle: begin
               end
               StHdrChk: begin
                  if (din_eop) begin
                     drop      = 1'b1;
                     drop_code = 2'd3;
                  end else begin
                     seed = 1'b1;
                  end
               end
               StPayload: begin
                  pay_word = 1'b1;
                  if (din_eop) begin
                     // Judged on the totals including this final word.
                     if (ovf_q || full) begin
                        drop      = 1'b1;
                        drop_code = 2'd3;
                     end else if (cnt_inc != {1'b0, len_q} || len_q == 8'd0) begin
                        drop      = 1'b1;
                        drop_code = 2'd1;
                     end else if (acc_add != 16'hFFFF) begin
                        drop      = 1'b1;
                        drop_code = 2'd2;
                     end else begin
                        commit = 1'b1;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- datapath next state
   always_comb begin
      wptr_d = wptr_q;
      cptr_d = cptr_q;
      len_d  = len_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      ovf_d  = ovf_q;
      wr_en  = pay_word && !full;
      if (hdr_start) begin
         len_d = din[7:0];
         cnt_d = 9'd0;
         ovf_d = 1'b0;
      end
      if (seed) begin
         acc_d = din;
      end
      if (pay_word) begin
         cnt_d = cnt_inc;
         acc_d = acc_add;
         if (full) begin
            ovf_d = 1'b1;
         end
      end
      if (wr_en) begin
         wptr_d = wptr_q + (AW+1)'(1);
      end
      if (commit) begin
         cptr_d = wptr_d;
      end else if (drop) begin
         wptr_d = cptr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q     <= '0;
         cptr_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         err_vld_q  <= 1'b0;
         err_code_q <= 2'd0;
      end else begin
         wptr_q    <= wptr_d;
         cptr_q    <= cptr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         err_vld_q <= drop;
         if (drop) begin
            err_code_q <= drop_code;
         end
      end
   end

   // Buffer storage needs no reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wptr_q[AW-1:0]] <= {cnt_q == 9'd0, din_eop, din};
      end
   end

   // ---------------------------------------------------------------- output stage
   // The output register refills whenever it is empty or being consumed, which
   // gives back-to-back words under continuous ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr_q     <= '0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         dout_sop_q <= 1'b0;
         dout_eop_q <= 1'b0;
      end else if (!dout_vld_q || dout_rdy) begin
         if (rptr_q != cptr_q) begin
            {dout_sop_q, dout_eop_q, dout_q} <= mem[rptr_q[AW-1:0]];
            dout_vld_q <= 1'b1;
            rptr_q     <= rptr_q + (AW+1)'(1);
         end else begin
            dout_vld_q <= 1'b0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
         end
      end
   end

   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign dout_sop = dout_sop_q;
   assign dout_eop = dout_eop_q;
   assign err_vld  = err_vld_q;
   assign err_code = err_code_q;

   // ---------------------------------------------------------------- statistics
`ifdef PKT_STAT_CNT_EN
   logic [15:0] good_cnt_q, err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         good_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         if (commit && good_cnt_q != 16'hFFFF) begin
            good_cnt_q <= good_cnt_q + 16'd1;
         end
         if (drop && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   assign good_cnt = good_cnt_q;
   assign err_cnt  = err_cnt_q;
`else
   assign good_cnt = 16'd0;
   assign err_cnt  = 16'd0;
`endif

endmodule

// File: doc/pkt_hdr_check.md
PKT_HDR_CHECK -- requirements
Module: pkt_hdr_check

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have ports: din  in  16  packet word; din_vld  in  1  word valid; din_sop  in  1  first word; din_eop  in  1  last word.
REQ-003 SHALL have ports: dout  out  16  payload word; dout_vld  out  1  valid; dout_sop  out  1  first payload word; dout_eop  out  1  last payload word; dout_rdy  in  1  downstream accepts.
REQ-004 SHALL have ports: err_vld  out  1  one-cycle drop pulse; err_code  out  2  drop cause; good_cnt  out  16  accepted packets; err_cnt  out  16  dropped packets.
REQ-005 Parameter: DEPTH, default 512, payload buffer words (power of two, >= 256).

Function
REQ-006 Input packet format SHALL be: word0[7:0] = payload length L (word0[15:8] ignored), word1 = checksum, then payload words; input has no backpressure.
REQ-007 Checksum SHALL be the 16-bit ones-complement sum with end-around carry (s = acc + din, 17 bits; acc = s[15:0] + s[16]) over payload plus checksum word; packet good iff result == 16'hFFFF.
REQ-008 FSM SHALL have states IDLE, HDR_CHK, PAYLOAD: IDLE->HDR_CHK on vld&sop (latch L); HDR_CHK->PAYLOAD on vld (seed acc with word); PAYLOAD->IDLE on vld&eop.
REQ-009 In IDLE, vld words without sop SHALL be discarded silently.
REQ-010 Payload words (with sop/eop tags, 18 bits) SHALL be written at speculative write pointer; committed pointer advances only when the packet is good.
REQ-011 At eop SHALL check, priority high to low: overflow/truncation -> code 3; payload count != L or L == 0 -> code 1; checksum fail -> code 2; bad packet rolls write pointer back to committed pointer.
REQ-012 Buffer full (speculative wptr - rptr == DEPTH) SHALL drop further writes and mark the packet overflow.
REQ-013 eop in IDLE-exit or HDR_CHK state (packet < 3 words) SHALL drop with code 3, return to IDLE.
REQ-014 sop while in HDR_CHK or PAYLOAD SHALL abort current packet (code 3, rollback) and start a new header on the same word.
REQ-015 err_vld SHALL pulse one cycle, registered, in the cycle after the terminating word; err_code held until next pulse.
REQ-016 Output SHALL read only committed words; transfer occurs when dout_vld & dout_rdy; dout/sop/eop SHALL hold stable while dout_vld & !dout_rdy.
REQ-017 With dout_rdy=1 and empty buffer, first payload word SHALL appear with dout_vld=1 two cycles after the eop input cycle; subsequent words back-to-back.
REQ-018 Simultaneous write, commit and read in one cycle SHALL all take effect; pointers are log2(DEPTH)+1 bits, wrap naturally.

Reset
REQ-019 On rst: FSM IDLE, all pointers 0, acc 0, dout 0, dout_vld/sop/eop 0, err_vld 0, err_code 0, counters 0; buffer contents irrelevant.
REQ-020 rst mid-packet SHALL discard all buffered and partial packets; first post-reset output only from a packet whose sop arrives after rst deasserts.

Configuration
REQ-021 Macro PKT_STAT_CNT_EN: defined -> good_cnt/err_cnt increment on each commit/drop, saturate at 16'hFFFF; undefined -> both outputs constant 0, no counter logic.

Verification
REQ-022 Input 0x0003,0xFFF9,0x0001,0x0002,0x0003 (sop first, eop last), dout_rdy=1 -> dout 0x0001(sop),0x0002,0x0003(eop), first vld 2 cycles after eop; good_cnt=1.
REQ-023 Same packet with checksum 0xFFF8 -> no output, err_vld pulse, err_code=2, err_cnt=1.
REQ-024 Header 0x0004, checksum 0xFFF9, payload 1,2,3 -> dropped, err_code=1; carry case 0x0002,0xFFFE,0xFFFF,0x0001 -> accepted.
REQ-025 dout_rdy=0, three 200-word good packets -> first two buffered, third dropped err_code=3; raising dout_rdy yields exactly 400 words, two sop, two eop.
REQ-026 sop reasserted at payload word 2 of a packet, followed by a good 3-word packet -> first dropped code 3, second output intact; rst pulse mid-packet -> outputs 0, no stale words.
REQ-027 dout_rdy toggled every cycle during a 10-word packet -> all 10 words delivered in order, none duplicated.
